// File: rtl/mlp_seq_ctrl.sv
// Image-load and run sequencer for the MNIST MLP engine.
// Streams pixels into the image RAM, kicks the engine, then latches its class.
module mlp_seq_ctrl #(
  parameter int NUM_PIX    = 784,
  parameter int ADDR_W     = 10,
  parameter int RUN_CYCLES = 6500,
  parameter int CNT_W      = 13
) (
  input  logic              CK,
  input  logic              RB,
  input  logic              START_I,
  input  logic              ABORT_I,
  input  logic              PIX_VALID_I,
  input  logic [7:0]        PIX_DATA_I,
  output logic              PIX_READY_O,
  output logic              RAM_WE_O,
  output logic [ADDR_W-1:0] RAM_WADDR_O,
  output logic [7:0]        RAM_WDATA_O,
  output logic              MLP_EN_O,
  input  logic [7:0]        MLP_LED_I,
  output logic              BUSY_O,
  output logic              DONE_O,
  output logic [3:0]        CLASS_O,
  output logic              CLASS_ERR_O
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    KICK,
    RUN,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIX - 1);
  localparam logic [CNT_W-1:0]  LAST_RUN = CNT_W'(RUN_CYCLES - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
  logic [CNT_W-1:0]  run_q, run_d;
  logic              we_d;
  logic [ADDR_W-1:0] waddr_d;
  logic [7:0]        wdata_d;
  logic [3:0]        cls_d;
  logic              err_d;
  logic              hs;

  assign PIX_READY_O = (state_q == LOAD);
  assign MLP_EN_O    = (state_q == KICK);
  assign DONE_O      = (state_q == DONE);
  assign BUSY_O      = (state_q != IDLE);
  assign hs          = PIX_VALID_I & PIX_READY_O;

  always_ff @(posedge CK or negedge RB) begin
    if (!RB) begin
      state_q     <= IDLE;
      pix_q       <= '0;
      run_q       <= '0;
      RAM_WE_O    <= 1'b0;
      RAM_WADDR_O <= '0;
      RAM_WDATA_O <= '0;
      CLASS_O     <= '0;
      CLASS_ERR_O <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      run_q       <= run_d;
      RAM_WE_O    <= we_d;
      RAM_WADDR_O <= waddr_d;
      RAM_WDATA_O <= wdata_d;
      CLASS_O     <= cls_d;
      CLASS_ERR_O <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    run_d   = run_q;
    we_d    = 1'b0;
    waddr_d = RAM_WADDR_O;
    wdata_d = RAM_WDATA_O;
    cls_d   = CLASS_O;
    err_d   = CLASS_ERR_O;
    // Abort wins over everything, including a handshake in the same cycle
    if (ABORT_I) begin
      state_d = IDLE;
      pix_d   = '0;
      run_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (START_I) begin
            state_d = LOAD;
            pix_d   = '0;
          end
        end
        LOAD: begin
          if (hs) begin
            we_d    = 1'b1;
            waddr_d = pix_q;
            wdata_d = PIX_DATA_I;
            if (pix_q == LAST_PIX) begin
              state_d = FLUSH;
            end else begin
              pix_d = pix_q + 1'b1;
            end
          end
        end
        FLUSH: state_d = KICK;
        KICK: begin
          run_d   = '0;
          state_d = RUN;
        end
        RUN: begin
          if (run_q == LAST_RUN) begin
            state_d = DONE;
            cls_d   = MLP_LED_I[3:0];
            err_d   = (MLP_LED_I > 8'd9);
          end else begin
            run_d = run_q + 1'b1;
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_seq_ctrl.sv
// Scoreboard bench for mlp_seq_ctrl (NUM_PIX=4, RUN_CYCLES=8).
// Driver queues expected writes/EN/DONE; a negedge monitor pops and compares.
module tb_mlp_seq_ctrl;

  localparam int NP = 4;
  localparam int RC = 8;
  localparam int AW = 10;

  logic          CK = 1'b0;
  logic          RB = 1'b0;
  logic          START_I = 1'b0;
  logic          ABORT_I = 1'b0;
  logic          PIX_VALID_I = 1'b0;
  logic [7:0]    PIX_DATA_I = '0;
  logic          PIX_READY_O;
  logic          RAM_WE_O;
  logic [AW-1:0] RAM_WADDR_O;
  logic [7:0]    RAM_WDATA_O;
  logic          MLP_EN_O;
  logic [7:0]    MLP_LED_I = '0;
  logic          BUSY_O;
  logic          DONE_O;
  logic [3:0]    CLASS_O;
  logic          CLASS_ERR_O;

  mlp_seq_ctrl #(
    .NUM_PIX(NP), .ADDR_W(AW), .RUN_CYCLES(RC), .CNT_W(13)
  ) dut (
    .CK(CK), .RB(RB), .START_I(START_I), .ABORT_I(ABORT_I),
    .PIX_VALID_I(PIX_VALID_I), .PIX_DATA_I(PIX_DATA_I),
    .PIX_READY_O(PIX_READY_O), .RAM_WE_O(RAM_WE_O),
    .RAM_WADDR_O(RAM_WADDR_O), .RAM_WDATA_O(RAM_WDATA_O),
    .MLP_EN_O(MLP_EN_O), .MLP_LED_I(MLP_LED_I), .BUSY_O(BUSY_O),
    .DONE_O(DONE_O), .CLASS_O(CLASS_O), .CLASS_ERR_O(CLASS_ERR_O)
  );

  always #5 CK = ~CK;

  typedef struct { int a; int d; } wr_t;
  typedef struct { int c; int e; int t; } done_t;

  wr_t   wr_q[$];
  int    en_q[$];
  done_t done_q[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;

  always @(posedge CK) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every DUT event must match the head of its queue
  always @(negedge CK) begin
    if (RB) begin
      if (RAM_WE_O) begin
        if (wr_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("waddr", int'(RAM_WADDR_O), w.a);
          chk("wdata", int'(RAM_WDATA_O), w.d);
        end
      end
      if (MLP_EN_O) begin
        if (en_q.size() == 0) chk("unexpected_en", 1, 0);
        else chk("en_cycle", cyc, en_q.pop_front());
      end
      if (DONE_O) begin
        if (done_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          done_t e;
          e = done_q.pop_front();
          chk("done_cycle", cyc, e.t);
          chk("class", int'(CLASS_O), e.c);
          chk("class_err", int'(CLASS_ERR_O), e.e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic send(input int d, output int hs);
    bit got;
    got = 0;
    hs = -1;
    PIX_VALID_I = 1'b1;
    PIX_DATA_I = 8'(d);
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge CK);
      if (PIX_READY_O) begin
        hs = cyc;
        got = 1;
      end
      tick();
    end
    PIX_VALID_I = 1'b0;
    if (!got) chk("pix_accept_timeout", 0, 1);
  endtask

  task automatic wait_done(input bit drop);
    bit got;
    got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge CK);
      if (DONE_O) got = 1;
    end
    if (!got) chk("done_timeout", 0, 1);
    if (drop) START_I = 1'b0;
    tick();
  endtask

  // Loads one image; expected events pushed as each pixel is issued
  task automatic load_img(input bit do_start, input bit hold,
                          input int base, input int led, input bit gap);
    int hs;
    MLP_LED_I = 8'(led);
    if (do_start) begin
      START_I = 1'b1;
      tick();
      if (!hold) START_I = 1'b0;
    end
    for (int i = 0; i < NP; i++) begin
      wr_q.push_back('{i, base + i * 10});
      send(base + i * 10, hs);
      if (gap) tick();
    end
    en_q.push_back(hs + 2);
    done_q.push_back('{led & 15, (led > 9) ? 1 : 0, hs + 3 + RC});
  endtask

  initial begin
    #2;
    chk("reset_outputs", int'({PIX_READY_O, RAM_WE_O, RAM_WADDR_O,
        RAM_WDATA_O, MLP_EN_O, BUSY_O, DONE_O, CLASS_O, CLASS_ERR_O}), 0);
    tick();
    RB = 1'b1;
    tick();
    chk("idle_busy", int'(BUSY_O), 0);

    // Full run, back-to-back pixels
    load_img(1, 0, 10, 7, 0);
    wait_done(1);

    // Reset in the middle of RUN
    load_img(1, 0, 50, 5, 0);
    repeat (5) tick();
    chk("run_busy", int'(BUSY_O), 1);
    #2 RB = 1'b0;
    #1;
    chk("midrun_reset_outputs", int'({PIX_READY_O, RAM_WE_O, RAM_WADDR_O,
        RAM_WDATA_O, MLP_EN_O, BUSY_O, DONE_O, CLASS_O, CLASS_ERR_O}), 0);
    done_q.delete();
    #1 RB = 1'b1;
    tick();
    chk("post_reset_busy", int'(BUSY_O), 0);
    chk("post_reset_class", int'(CLASS_O), 0);

    // Gapped valid
    load_img(1, 0, 100, 2, 1);
    wait_done(1);

    // Abort after two pixels, then restart from address 0
    begin
      int hs;
      START_I = 1'b1;
      tick();
      START_I = 1'b0;
      wr_q.push_back('{0, 201});
      send(201, hs);
      wr_q.push_back('{1, 202});
      send(202, hs);
      ABORT_I = 1'b1;
      tick();
      ABORT_I = 1'b0;
      chk("abort_idle", int'(BUSY_O), 0);
      chk("abort_class_kept", int'(CLASS_O), 2);
      repeat (3) tick();
    end
    load_img(1, 0, 30, 9, 0);
    wait_done(1);

    // Out-of-range class, then a normal one
    load_img(1, 0, 60, 12, 0);
    wait_done(1);
    chk("err_latched", int'(CLASS_ERR_O), 1);
    load_img(1, 0, 70, 3, 0);
    wait_done(1);
    chk("err_cleared", int'(CLASS_ERR_O), 0);

    // START held high: DONE cycle ignores it, IDLE picks it up again
    load_img(1, 1, 80, 4, 0);
    wait_done(0);
    chk("idle_after_done", int'(BUSY_O), 0);
    tick();
    chk("reload_from_idle", int'(PIX_READY_O), 1);
    load_img(0, 1, 90, 6, 0);
    wait_done(1);
    chk("final_idle", int'(BUSY_O), 0);

    repeat (15) tick();
    chk("wr_q_empty", wr_q.size(), 0);
    chk("en_q_empty", en_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
